// File: rtl/uni_arb2.sv
// uni_arb2: two-master (IFU=m0, LSU=m1) to one-slave uni_if arbiter with stall watchdog.
// Optional: define UNI_ARB_RR_EN for round-robin tie-break in IDLE (default: m1 over m0).
module uni_arb2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_reqtyp,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m0_cachable,
    input  logic [1:0]        m0_size,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_reqtyp,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_cachable,
    input  logic [1:0]        m1_size,

    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_reqtyp,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              s_cachable,
    output logic [1:0]        s_size,

    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;

    logic own0, own1;
    logic own_valid, oth_valid;
    logic done;
    logic pick1;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    assign own_valid = (own0 & m0_valid) | (own1 & m1_valid);
    assign oth_valid = (own0 & m1_valid) | (own1 & m0_valid);
    assign done      = own_valid & s_ready;

`ifdef UNI_ARB_RR_EN
    // last_q = 0 means m0 was served last, so m1 takes a tie
    assign pick1 = m1_valid & (~m0_valid | ~last_q);
`else
    assign pick1 = m1_valid;
`endif

    always_comb begin
        s_valid    = 1'b0;
        s_reqtyp   = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        s_cachable = 1'b0;
        s_size     = 2'b00;
        if (own0) begin
            s_valid    = m0_valid;
            s_reqtyp   = m0_reqtyp;
            s_addr     = m0_addr;
            s_wdata    = m0_wdata;
            s_cachable = m0_cachable;
            s_size     = m0_size;
        end else if (own1) begin
            s_valid    = m1_valid;
            s_reqtyp   = m1_reqtyp;
            s_addr     = m1_addr;
            s_wdata    = m1_wdata;
            s_cachable = m1_cachable;
            s_size     = m1_size;
        end
    end

    assign m0_ready    = own0 & m0_valid & s_ready;
    assign m1_ready    = own1 & m1_valid & s_ready;
    assign m0_rdata    = s_rdata;
    assign m1_rdata    = s_rdata;
    assign grant       = {own1, own0};
    assign timeout_err = err_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (m0_valid | m1_valid) begin
                    state_d = pick1 ? OWN1 : OWN0;
                    wd_d    = '0;
                end
            end
            OWN0, OWN1: begin
                if (done) begin
                    // hand-off considers only the other master
                    last_d  = own1;
                    wd_d    = '0;
                    state_d = oth_valid ? (own0 ? OWN1 : OWN0) : IDLE;
                end else if (!own_valid) begin
                    state_d = IDLE;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + CNT_W'(1);
                    if (wd_q == WD_LAST) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_uni_arb2.sv
// tb_uni_arb2: directed plan scenarios plus random traffic against an owner-level model.
module tb_uni_arb2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mv, mt, mc;
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [1:0]  ms [2];
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready, s_reqtyp, s_cachable;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  s_size, grant;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    // model: owner (-1 idle), last served master, stalled-cycle count, sticky error
    int own, last, wd;
    bit err;
    bit [1:0] pend;

    always #5 clk = ~clk;

    uni_arb2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_reqtyp(mt[0]),
        .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_rdata(m0_rdata),
        .m0_cachable(mc[0]), .m0_size(ms[0]),
        .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_reqtyp(mt[1]),
        .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_rdata(m1_rdata),
        .m1_cachable(mc[1]), .m1_size(ms[1]),
        .s_valid(s_valid), .s_ready(s_ready), .s_reqtyp(s_reqtyp),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_cachable(s_cachable), .s_size(s_size),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [1:0]  g;
        logic        v, t, c;
        logic [31:0] a, w;
        logic [1:0]  sz;
        g = 2'b00; v = 0; t = 0; c = 0; a = 0; w = 0; sz = 0;
        if (own >= 0) begin
            g  = (own == 1) ? 2'b10 : 2'b01;
            v  = mv[own];
            t  = mt[own];
            c  = mc[own];
            a  = ma[own];
            w  = mw[own];
            sz = ms[own];
        end
        chk("grant", grant, g);
        chk("s_valid", s_valid, v);
        chk("s_reqtyp", s_reqtyp, t);
        chk("s_cachable", s_cachable, c);
        chk("s_addr", s_addr, a);
        chk("s_wdata", s_wdata, w);
        chk("s_size", s_size, sz);
        chk("m0_ready", m0_ready, (own == 0) && mv[0] && s_ready);
        chk("m1_ready", m1_ready, (own == 1) && mv[1] && s_ready);
        chk("m0_rdata", m0_rdata, s_rdata);
        chk("m1_rdata", m1_rdata, s_rdata);
        chk("timeout_err", timeout_err, err);
    endtask

    task automatic model_update();
        int x;
        if (!rst_n) begin
            own = -1; last = 0; wd = 0; err = 0;
        end else if (own < 0) begin
            if (mv != 2'b00) begin
`ifdef UNI_ARB_RR_EN
                if (mv == 2'b11) own = (last == 0) ? 1 : 0;
                else own = mv[1] ? 1 : 0;
`else
                own = mv[1] ? 1 : 0;
`endif
                wd = 0;
            end
        end else begin
            x = own;
            if (mv[x] && s_ready) begin
                last = x;
                wd = 0;
                own = mv[1-x] ? 1 - x : -1;
            end else if (!mv[x]) begin
                own = -1;
            end else if (wd < TO) begin
                wd++;
                if (wd == TO) err = 1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        rst_n = 0; mv = 0; mt = 0; mc = 0; s_ready = 0; s_rdata = 0;
        for (int i = 0; i < 2; i++) begin
            ma[i] = 0; mw[i] = 0; ms[i] = 0;
        end
        own = -1; last = 0; wd = 0; err = 0; pend = 0;
        @(posedge clk);
        #1;
        step();
        rst_n = 1;
        step();
        chk("reset_grant", grant, 2'b00);

        // single read from m0, slave answers on third owned cycle
        mv[0] = 1; mt[0] = 0; ma[0] = 32'h8000_0000; ms[0] = 2'b10;
        step();
        settle();
        chk("rd_s_valid", s_valid, 1'b1);
        chk("rd_s_addr", s_addr, 32'h8000_0000);
        adv();
        step();
        s_ready = 1; s_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rd_ready", m0_ready, 1'b1);
        chk("rd_data", m0_rdata, 32'hDEAD_BEEF);
        adv();
        mv[0] = 0; s_ready = 0;
        settle();
        chk("rd_idle", grant, 2'b00);
        adv();

        // simultaneous requests: m1 write first, then m0 read with no bubble
        mv = 2'b11; mt = 2'b10;
        ma[0] = 32'h100; ma[1] = 32'h200; mw[1] = 32'h55; s_ready = 1;
        step();
        settle();
        chk("sim_first", grant, 2'b10);
        chk("sim_wdata", s_wdata, 32'h55);
        adv();
        mv[1] = 0;
        settle();
        chk("sim_second", grant, 2'b01);
        chk("sim_m0_ready", m0_ready, 1'b1);
        adv();
        mv[0] = 0;
        step();

        // fairness with both valids held high
        mv = 2'b11;
        step();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("fair_grant", grant, (i % 2 == 0) ? 2'b10 : 2'b01);
            adv();
        end
        mv = 0; s_ready = 0;
        step();
        step();

        // abort: m0 drops valid while stalled
        mv[0] = 1;
        step();
        settle();
        chk("abort_own", grant, 2'b01);
        adv();
        mv[0] = 0;
        settle();
        chk("abort_no_ready", m0_ready, 1'b0);
        adv();
        settle();
        chk("abort_idle", grant, 2'b00);
        adv();

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1;
                    mt[i] = 1'($urandom);
                    mc[i] = 1'($urandom);
                    ma[i] = $urandom;
                    mw[i] = $urandom;
                    ms[i] = 2'($urandom);
                end else if (pend[i] && $urandom_range(39) == 0) begin
                    pend[i] = 0;
                end
                mv[i] = pend[i];
            end
            s_ready = ($urandom_range(2) != 0);
            s_rdata = $urandom;
            settle();
            for (int i = 0; i < 2; i++) begin
                if (own == i && mv[i] && s_ready) pend[i] = 0;
            end
            adv();
        end
        mv = 0; pend = 0; s_ready = 0;
        step();
        step();

        // reset while m1 owns a stalled transfer
        mv[1] = 1; mt[1] = 0;
        step();
        settle();
        chk("rst_pre_own", grant, 2'b10);
        adv();
        rst_n = 0;
        step();
        rst_n = 1; mv[1] = 0;
        settle();
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_m1_ready", m1_ready, 1'b0);
        chk("rst_err", timeout_err, 1'b0);
        adv();

        // watchdog: error rises exactly TO owned cycles after grant
        mv[1] = 1;
        step();
        for (int i = 0; i < TO; i++) begin
            settle();
            chk("wd_pre", timeout_err, 1'b0);
            chk("wd_grant", grant, 2'b10);
            adv();
        end
        s_ready = 1;
        settle();
        chk("wd_err", timeout_err, 1'b1);
        chk("wd_done", m1_ready, 1'b1);
        adv();
        mv[1] = 0; s_ready = 0;
        settle();
        chk("wd_sticky", timeout_err, 1'b1);
        chk("wd_idle", grant, 2'b00);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
